array_copier: RTL and testbench

Initiator for the testbench array port: accepts a block-copy command and moves `len` words from `src` to `dst` inside an attached array model. It uses the array's valid/ready handshake and its one-cycle registered read data. It sits between a bench stimulus driver and the array, so benches can exercise multi-word traffic with the array's stalling `ready` behaviour. An optional running sum of copied words is available for scoreboarding.

---
 rtl/array_copier.sv | 174 +++++++++++++++++
 tb/tb_array_copier.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_copier.sv
// ---------------------------------------------------------------------------
// array_copier
//
// Block-copy initiator for the bench array port. Accepts one command
// (src, dst, len) and copies len words from src.. to dst.. in ascending order.
// Each word is one read (RD), one cycle of read latency (LAT) and one write
// (WR), using the array's valid/ready handshake.
//
// Configuration macro: ARRAY_COPIER_SUM_EN
//   defined   -> running sum of the copied words is kept and driven on sum
//   undefined -> no accumulator is built, sum is tied to 0
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   start_valid  copy command present
//   start_ready  idle, command can be accepted
//   src/dst/len  first source, first destination, word count (sampled on accept)
//   busy         copy in progress (RD, LAT, WR, FIN)
//   done         one-cycle pulse when the copy completes
//   sum          sum of words copied by the last or current command
//   mem_addr, mem_we, mem_di, mem_valid   array request
//   mem_ready, mem_do                     array ready / registered read data
// ---------------------------------------------------------------------------
`ifndef addrT
`define addrT logic [15:0]
`endif
`ifndef intT
`define intT logic [31:0]
`endif

module array_copier (
   input  logic   clk,
   input  logic   rst,
   input  logic   start_valid,
   output logic   start_ready,
   input  `addrT  src,
   input  `addrT  dst,
   input  `addrT  len,
   output logic   busy,
   output logic   done,
   output `intT   sum,
   output `addrT  mem_addr,
   output logic   mem_we,
   output `intT   mem_di,
   output logic   mem_valid,
   input  logic   mem_ready,
   input  `intT   mem_do
);

   typedef `addrT addr_t;
   typedef `intT  int_t;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_LAT  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   logic [2:0] state_q, state_d;
   addr_t      src_q, src_d;
   addr_t      dst_q, dst_d;
   addr_t      len_q, len_d;
   addr_t      idx_q, idx_d;
   int_t       hold_q, hold_d;
   addr_t      idx_inc;

   // Index and address arithmetic wrap naturally at the addrT width.
   assign idx_inc = idx_q + addr_t'(1);

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               src_d   = src;
               dst_d   = dst;
               len_d   = len;
               idx_d   = '0;
               state_d = (len == '0) ? S_FIN : S_RD;
            end
         end
         S_RD:  if (mem_ready) state_d = S_LAT;
         S_LAT: begin
            // mem_do is only valid in this cycle; capture it for the write.
            hold_d  = mem_do;
            state_d = S_WR;
         end
         S_WR: begin
            if (mem_ready) begin
               idx_d   = idx_inc;
               state_d = (idx_inc == len_q) ? S_FIN : S_RD;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
      end
   end

`ifdef ARRAY_COPIER_SUM_EN
   int_t sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (state_q == S_IDLE && start_valid)
         sum_d = '0;
      else if (state_q == S_WR && mem_ready)
         sum_d = sum_q + hold_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sum_q <= '0;
      else     sum_q <= sum_d;
   end

   assign sum = sum_q;
`else
   assign sum = '0;
`endif

   // Outputs decode straight from the state register. mem_we follows
   // mem_ready combinationally in WR so the array, which writes whenever we
   // is high, sees exactly one write per word; reset forces IDLE
   // asynchronously, which drops mem_we at once.
   always_comb begin
      start_ready = (state_q == S_IDLE);
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_FIN);
      mem_valid   = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_di      = '0;
      case (state_q)
         S_RD: begin
            mem_valid = 1'b1;
            mem_addr  = src_q + idx_q;
         end
         S_WR: begin
            mem_valid = 1'b1;
            mem_we    = mem_ready;
            mem_addr  = dst_q + idx_q;
            mem_di    = hold_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_array_copier.sv
// ---------------------------------------------------------------------------
// tb_array_copier
//
// Self-checking bench for array_copier. A behavioural array (64 words,
// data[i]=i after init) answers the handshake with registered read data and a
// ready line that toggles, is random, or is held low. A reference model
// copies words one at a time in ascending order and accumulates their sum.
// sum is expected to be 0 when ARRAY_COPIER_SUM_EN is not defined.
// ---------------------------------------------------------------------------
`ifndef addrT
`define addrT logic [15:0]
`endif
`ifndef intT
`define intT logic [31:0]
`endif

module tb_array_copier;

   typedef `addrT addr_t;
   typedef `intT  int_t;

   localparam int DEPTH = 64;

   logic  clk = 1'b0;
   logic  rst;
   logic  start_valid;
   logic  start_ready;
   addr_t src, dst, len;
   logic  busy, done;
   int_t  sum;
   addr_t mem_addr;
   logic  mem_we;
   int_t  mem_di;
   logic  mem_valid;
   logic  mem_ready = 1'b0;
   int_t  mem_do;

   int checks   = 0;
   int failures = 0;

   int_t mem_arr [DEPTH];
   int_t ref_arr [DEPTH];
   logic init_req   = 1'b0;
   int   ready_mode = 0;   // 0 toggle, 1 random, 2 held low
   int   we_cycles    = 0;
   int   valid_cycles = 0;
   int   done_cycles  = 0;

   array_copier dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .src         (src),
      .dst         (dst),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .sum         (sum),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_di      (mem_di),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_do      (mem_do)
   );

   always #5 clk = ~clk;

   // Array model: writes whenever we is high, read data registered on the
   // handshake edge. Also counts activity for the checks.
   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < DEPTH; i++) mem_arr[i] = int_t'(i);
      end else begin
         if (mem_valid && mem_ready && !mem_we) mem_do <= mem_arr[mem_addr[5:0]];
         if (mem_we) mem_arr[mem_addr[5:0]] = mem_di;
      end
      if (mem_we)    we_cycles++;
      if (mem_valid) valid_cycles++;
      if (done)      done_cycles++;
   end

   always @(negedge clk) begin
      case (ready_mode)
         0:       mem_ready = ~mem_ready;
         1:       mem_ready = 1'($urandom_range(0, 1));
         default: mem_ready = 1'b0;
      endcase
   end

   // ---------------- reference model and helpers ----------------
   function automatic int_t ref_copy(int s, int d, int l);
      int_t acc = '0;
      for (int k = 0; k < l; k++) begin
         ref_arr[(d + k) % DEPTH] = ref_arr[(s + k) % DEPTH];
         acc += ref_arr[(s + k) % DEPTH];
      end
      return acc;
   endfunction

   function automatic int_t exp_sum(int_t model_sum);
`ifdef ARRAY_COPIER_SUM_EN
      return model_sum;
`else
      return '0;
`endif
   endfunction

   function automatic int mem_diff();
      for (int i = 0; i < DEPTH; i++)
         if (mem_arr[i] !== ref_arr[i]) return i;
      return -1;
   endfunction

   task automatic init_mem();
      for (int i = 0; i < DEPTH; i++) ref_arr[i] = int_t'(i);
      @(negedge clk);
      init_req = 1'b1;
      @(posedge clk);
      #1 init_req = 1'b0;
   endtask

   task automatic start_cmd(int s, int d, int l);
      @(negedge clk);
      start_valid = 1'b1;
      src = addr_t'(s);
      dst = addr_t'(d);
      len = addr_t'(l);
      @(posedge clk);
      #1 start_valid = 1'b0;
   endtask

   task automatic wait_done(int max_cycles, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < max_cycles && !seen; c++) begin
         @(negedge clk);
         #1;
         if (done) seen = 1'b1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      start_valid = 1'b0;
      src = '0; dst = '0; len = '0;
      #12;
      checks++;
      if ({start_ready, busy, done, mem_valid, mem_we} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=%b", {start_ready, busy, done, mem_valid, mem_we}, 5'b10000);
      end
      checks++;
      if (sum !== '0 || mem_addr !== '0 || mem_di !== '0) begin
         failures++;
         $display("FAIL reset_data sum=%0d addr=%0d di=%0d exp=0", sum, mem_addr, mem_di);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int we0, dn0, bad;
      bit seen;
      int_t ms;
      ready_mode = 0;
      init_mem();
      ms = ref_copy(2, 8, 4);
      we0 = we_cycles; dn0 = done_cycles;
      start_cmd(2, 8, 4);
      wait_done(100, seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL basic_done timeout got=0 exp=1"); end
      checks++;
      if (busy !== 1'b1 || start_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_fin busy=%b start_ready=%b exp=1/0", busy, start_ready);
      end
      checks++;
      if (sum !== exp_sum(ms)) begin failures++; $display("FAIL basic_sum got=%0d exp=%0d", sum, exp_sum(ms)); end
      @(negedge clk); #1;
      checks++;
      if (start_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_idle start_ready=%b busy=%b exp=1/0", start_ready, busy);
      end
      repeat (3) @(negedge clk);
      bad = mem_diff();
      checks++;
      if (bad >= 0) begin failures++; $display("FAIL basic_mem addr=%0d got=%0d exp=%0d", bad, mem_arr[bad], ref_arr[bad]); end
      checks++;
      if (mem_arr[11] !== int_t'(5)) begin failures++; $display("FAIL basic_word11 got=%0d exp=5", mem_arr[11]); end
      checks++;
      if (we_cycles - we0 != 4) begin failures++; $display("FAIL basic_we_count got=%0d exp=4", we_cycles - we0); end
      checks++;
      if (done_cycles - dn0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cycles - dn0); end
   endtask

   task automatic test_overlap();
      int bad;
      bit seen;
      int_t ms;
      ready_mode = 0;
      init_mem();
      ms = ref_copy(0, 1, 3);
      start_cmd(0, 1, 3);
      wait_done(100, seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL overlap_done timeout got=0 exp=1"); end
      checks++;
      if (sum !== exp_sum(ms)) begin failures++; $display("FAIL overlap_sum got=%0d exp=%0d", sum, exp_sum(ms)); end
      @(negedge clk);
      bad = mem_diff();
      checks++;
      if (bad >= 0) begin failures++; $display("FAIL overlap_mem addr=%0d got=%0d exp=%0d", bad, mem_arr[bad], ref_arr[bad]); end
      checks++;
      if (mem_arr[3] !== '0) begin failures++; $display("FAIL overlap_word3 got=%0d exp=0", mem_arr[3]); end
   endtask

   task automatic test_zero_len();
      int v0, w0, bad;
      ready_mode = 0;
      init_mem();
      v0 = valid_cycles; w0 = we_cycles;
      start_cmd(5, 20, 0);
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
      checks++;
      if (sum !== '0) begin failures++; $display("FAIL zero_sum got=%0d exp=0", sum); end
      repeat (4) @(negedge clk);
      checks++;
      if (valid_cycles != v0 || we_cycles != w0) begin
         failures++;
         $display("FAIL zero_quiet valid=%0d we=%0d exp=0/0", valid_cycles - v0, we_cycles - w0);
      end
      bad = mem_diff();
      checks++;
      if (bad >= 0) begin failures++; $display("FAIL zero_mem addr=%0d got=%0d exp=%0d", bad, mem_arr[bad], ref_arr[bad]); end
   endtask

   task automatic test_stall();
      addr_t a0;
      bit seen, stable;
      int bad;
      int_t ms;
      ready_mode = 2;
      init_mem();
      ms = ref_copy(4, 30, 3);
      start_cmd(4, 30, 3);
      @(negedge clk); #1;
      a0 = mem_addr;
      stable = (mem_valid === 1'b1) && (a0 === addr_t'(4));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (mem_addr !== a0 || mem_we !== 1'b0 || mem_valid !== 1'b1) stable = 1'b0;
      end
      checks++;
      if (!stable) begin failures++; $display("FAIL stall_hold addr=%0d we=%b valid=%b exp=4/0/1", mem_addr, mem_we, mem_valid); end
      ready_mode = 0;
      wait_done(100, seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL stall_done timeout got=0 exp=1"); end
      checks++;
      if (sum !== exp_sum(ms)) begin failures++; $display("FAIL stall_sum got=%0d exp=%0d", sum, exp_sum(ms)); end
      @(negedge clk);
      bad = mem_diff();
      checks++;
      if (bad >= 0) begin failures++; $display("FAIL stall_mem addr=%0d got=%0d exp=%0d", bad, mem_arr[bad], ref_arr[bad]); end
   endtask

   task automatic test_reset_mid();
      bit hit, seen;
      int bad;
      int_t ms;
      ready_mode = 0;
      init_mem();
      void'(ref_copy(10, 40, 2));
      start_cmd(10, 40, 4);
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk); #1;
         if (mem_valid && mem_addr == addr_t'(42)) hit = 1'b1;
      end
      checks++;
      if (!hit) begin failures++; $display("FAIL rstmid_reach timeout got=0 exp=1"); end
      rst = 1'b1;
      #1;
      checks++;
      if ({start_ready, busy, done, mem_valid, mem_we} !== 5'b10000 || sum !== '0 || mem_addr !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs ctrl=%b sum=%0d addr=%0d exp=10000/0/0",
                  {start_ready, busy, done, mem_valid, mem_we}, sum, mem_addr);
      end
      repeat (3) @(negedge clk);
      bad = mem_diff();
      checks++;
      if (bad >= 0) begin failures++; $display("FAIL rstmid_mem addr=%0d got=%0d exp=%0d", bad, mem_arr[bad], ref_arr[bad]); end
      rst = 1'b0;
      ms = ref_copy(0, 50, 2);
      start_cmd(0, 50, 2);
      wait_done(100, seen);
      checks++;
      if (!seen || sum !== exp_sum(ms)) begin
         failures++;
         $display("FAIL rstmid_next done=%b sum=%0d exp=1/%0d", seen, sum, exp_sum(ms));
      end
      @(negedge clk);
      bad = mem_diff();
      checks++;
      if (bad >= 0) begin failures++; $display("FAIL rstmid_next_mem addr=%0d got=%0d exp=%0d", bad, mem_arr[bad], ref_arr[bad]); end
   endtask

   task automatic test_busy_ignore();
      int dn0, bad;
      bit seen;
      int_t ms;
      ready_mode = 0;
      init_mem();
      ms = ref_copy(20, 3, 3);
      dn0 = done_cycles;
      start_cmd(20, 3, 3);
      // A second command is presented throughout the copy and must be ignored.
      start_valid = 1'b1;
      src = addr_t'(0); dst = addr_t'(60); len = addr_t'(2);
      wait_done(100, seen);
      start_valid = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (!seen || done_cycles - dn0 != 1) begin
         failures++;
         $display("FAIL busy_ignore done_count got=%0d exp=1", done_cycles - dn0);
      end
      checks++;
      if (sum !== exp_sum(ms)) begin failures++; $display("FAIL busy_ignore_sum got=%0d exp=%0d", sum, exp_sum(ms)); end
      bad = mem_diff();
      checks++;
      if (bad >= 0) begin failures++; $display("FAIL busy_ignore_mem addr=%0d got=%0d exp=%0d", bad, mem_arr[bad], ref_arr[bad]); end
   endtask

   task automatic test_random();
      int s, d, l, bad;
      bit seen;
      int_t ms;
      ready_mode = 1;
      init_mem();
      for (int n = 0; n < 10; n++) begin
         s = int'($urandom_range(0, 40));
         d = int'($urandom_range(0, 40));
         l = int'($urandom_range(0, 12));
         ms = ref_copy(s, d, l);
         start_cmd(s, d, l);
         wait_done(300, seen);
         checks++;
         if (!seen || sum !== exp_sum(ms)) begin
            failures++;
            $display("FAIL random_%0d src=%0d dst=%0d len=%0d done=%b sum=%0d exp=%0d", n, s, d, l, seen, sum, exp_sum(ms));
         end
         @(negedge clk);
         bad = mem_diff();
         checks++;
         if (bad >= 0) begin
            failures++;
            $display("FAIL random_mem_%0d addr=%0d got=%0d exp=%0d", n, bad, mem_arr[bad], ref_arr[bad]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overlap();
      test_zero_len();
      test_stall();
      test_reset_mid();
      test_busy_ignore();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
